multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Execution-side consumer of the 4-bit alu_control code produced by the ALU decoder.
- Executes single-cycle logic and arithmetic ops in one cycle.
- Executes MUL, DIV and MOD iteratively: one bit per cycle, shift-add or restoring.
- Uses a start/busy/done handshake so the multicycle controller can stall while long ops run.

Parameters:
- WIDTH, 32, operand and result width. Must be even and ≥16. Also sets the iteration count for MUL/DIV/MOD.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request an op; accepted only in IDLE
- alu_control  input  4  op code, sampled with start
- a  input  WIDTH  operand A (rs); sampled with start
- b  input  WIDTH  operand B (rt/imm); sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  registered result; held until the next accepted op
- zero  output  1  registered (result == 0)
- div_by_zero  output  1  DIV/MOD issued with b == 0; held with result
- illegal_op  output  1  unrecognised alu_control; held with result

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - busy, done, zero, div_by_zero, illegal_op = 0; result = 0.
  - Any in-progress op is discarded.
- Op codes and results:
  - AND 0000: a&b
  - OR 0001: a|b
  - ADD 0010: a+b, wraps, no overflow trap
  - SUB 0110: a-b
  - SLT 0111: signed compare; 1 if a<b else 0
  - NOR 1100: ~(a|b)
  - LUI 1000: {b[WIDTH/2-1:0], WIDTH/2 zeros}
  - MUL 1001: low WIDTH bits of a*b (sign-agnostic)
  - DIV 1010: signed quotient, truncated toward zero
  - MOD 1011: signed remainder; sign follows dividend
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE.
- IDLE, start=1:
  - Latch operands and op; clear the flags.
  - Single-cycle op → DONE, result written at the same edge.
  - Unrecognised code → DONE, result=0, illegal_op=1.
  - DIV/MOD with b==0 → DONE, result = all-ones for DIV or a for MOD, div_by_zero=1.
  - MUL → MUL_RUN, count=0.
  - DIV/MOD → DIV_RUN, count=0, operands converted to magnitudes, signs stored.
- MUL_RUN: one shift-add step per cycle; after WIDTH steps → DONE, result = product low bits.
- DIV_RUN: one restoring step per cycle; after WIDTH steps → DIV_FIX.
- DIV_FIX: apply signs (quotient negated if signs differ; remainder takes dividend sign); write result → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Latency, counted from the edge that samples start to the first cycle with done high:
  - single-cycle ops and error cases: 1
  - MUL: WIDTH+1 (33)
  - DIV/MOD: WIDTH+2 (34)
- start while busy (including the DONE cycle) is ignored; no queueing.
- Operand changes after acceptance have no effect.
- zero is updated at the same edge as result.
- Overflow case: DIV of most-negative / -1 gives most-negative (0x80000000); MOD gives 0. No flag.
- back-to-back: start asserted in the cycle after done (IDLE) is accepted; minimum issue interval is 2 cycles.

Decomposition:
- Shared package alu_pkg holds:
  - alu_ops_t enum (AND_OP…MOD_OP), reused by the decoder and this block
  - the state enum
  - the default WIDTH constant
- Natural sub-module: seq_muldiv.
  - Owns the iteration counter, the shift-add and restoring datapaths, and the sign fix.
  - Handshake: go, op_is_div, a, b → ready, quotient/product, remainder.
- The top-level module keeps the FSM, the single-cycle ops, and the flag/result registers.

Test Plan:
- ADD a=7, b=5 at cycle 0 → done at cycle 1, result=12, zero=0. SUB a=5, b=5 → result=0, zero=1.
- SLT a=0xFFFFFFFF (-1), b=1 → 1. LUI b=0x00001234 → 0x12340000. NOR a=0, b=0 → 0xFFFFFFFF.
- MUL a=-3 (0xFFFFFFFD), b=7 → busy for 33 cycles, done at cycle 33, result 0xFFFFFFEB (-21). start pulsed mid-run is ignored.
- DIV a=-7, b=2 → done at cycle 34, result 0xFFFFFFFD (-3). MOD a=-7, b=2 → 0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- DIV a=9, b=0 → done at cycle 1, result 0xFFFFFFFF, div_by_zero=1. Code 0101 → result 0, illegal_op=1. The next valid op clears both flags.
- rst_n low at cycle 10 of a MUL → busy/done/result cleared immediately. After release, ADD 1+1 issues normally, result 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   alu_ops_t   : 4-bit alu_control encoding (shared with the ALU decoder)
//   alu_state_t : multicycle_alu controller states
//   ALU_WIDTH   : default datapath width
//   is_single_cycle() : true for ops that complete at the accepting edge
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    AND_OP = 4'b0000,
    OR_OP  = 4'b0001,
    ADD_OP = 4'b0010,
    SUB_OP = 4'b0110,
    SLT_OP = 4'b0111,
    LUI_OP = 4'b1000,
    MUL_OP = 4'b1001,
    DIV_OP = 4'b1010,
    MOD_OP = 4'b1011,
    NOR_OP = 4'b1100
  } alu_ops_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    DIV_FIX,
    DONE
  } alu_state_t;

  function automatic logic is_single_cycle(logic [3:0] code);
    case (code)
      AND_OP, OR_OP, ADD_OP, SUB_OP, SLT_OP, LUI_OP, NOR_OP: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative multiply / signed divide, one bit per cycle.
//   go        : load operands and start (op_is_div selects divide)
//   ready     : high during the cycle whose step is the final iteration
//   quo_prod  : MUL -> product after the current step (valid with ready)
//               DIV -> sign-corrected quotient (valid the cycle after ready)
//   remainder : sign-corrected remainder (valid the cycle after ready)
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] quo_prod,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  // Registers are shared between the two algorithms:
  //   hi : MUL accumulator        / DIV partial remainder
  //   md : MUL shifted multiplicand / DIV divisor magnitude
  //   lo : MUL shifted multiplier   / DIV dividend shifting out, quotient in
  logic [WIDTH-1:0] hi, md, lo;
  logic [CW-1:0]    cnt;
  logic             running, is_div, neg_q, neg_r;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]   rem_sh, diff;
  logic             diff_ok;

  assign acc_nxt = hi + (lo[0] ? md : '0);
  assign rem_sh  = {hi, lo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, md};
  assign diff_ok = ~diff[WIDTH];

  assign ready     = running && (cnt == CW'(WIDTH - 1));
  assign quo_prod  = is_div ? (neg_q ? -lo : lo) : acc_nxt;
  assign remainder = neg_r ? -hi : hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      md      <= '0;
      lo      <= '0;
      cnt     <= '0;
      running <= 1'b0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (go) begin
      cnt     <= '0;
      running <= 1'b1;
      is_div  <= op_is_div;
      hi      <= '0;
      if (op_is_div) begin
        // Magnitudes as unsigned; -MIN wraps to MIN which is the correct
        // unsigned magnitude.
        md    <= b[WIDTH-1] ? -b : b;
        lo    <= a[WIDTH-1] ? -a : a;
        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_r <= a[WIDTH-1];
      end else begin
        md    <= a;
        lo    <= b;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end
    end else if (running) begin
      cnt <= cnt + CW'(1);
      if (ready) running <= 1'b0;
      if (is_div) begin
        hi <= diff_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], diff_ok};
      end else begin
        hi <= acc_nxt;
        md <= {md[WIDTH-2:0], 1'b0};
        lo <= {1'b0, lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative MUL/DIV/MOD.
//   clk, rst_n          : clock, async active-low reset
//   start, alu_control  : op request (accepted only in IDLE)
//   a, b                : operands, sampled with start
//   busy                : controller not in IDLE
//   done                : one-cycle pulse, result valid
//   result, zero        : registered result and (result == 0)
//   div_by_zero         : DIV/MOD with b == 0
//   illegal_op          : unrecognised alu_control
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  alu_state_t       state;
  logic             is_mod;
  logic [WIDTH-1:0] sc_res, fix_res, dz_res;
  logic             is_mul, is_dm, b_zero, go;
  logic             md_ready;
  logic [WIDTH-1:0] md_qp, md_rem;

  assign is_mul = (alu_control == MUL_OP);
  assign is_dm  = (alu_control == DIV_OP) || (alu_control == MOD_OP);
  assign b_zero = (b == '0);
  assign go     = (state == IDLE) && start && (is_mul || (is_dm && !b_zero));
  assign dz_res = (alu_control == DIV_OP) ? '1 : a;
  assign fix_res = is_mod ? md_rem : md_qp;

  always_comb begin
    sc_res = '0;
    case (alu_control)
      AND_OP: sc_res = a & b;
      OR_OP:  sc_res = a | b;
      ADD_OP: sc_res = a + b;
      SUB_OP: sc_res = a - b;
      SLT_OP: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      NOR_OP: sc_res = ~(a | b);
      LUI_OP: sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: sc_res = '0;
    endcase
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .op_is_div (is_dm),
    .a         (a),
    .b         (b),
    .ready     (md_ready),
    .quo_prod  (md_qp),
    .remainder (md_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      is_mod      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          div_by_zero <= 1'b0;
          illegal_op  <= 1'b0;
          is_mod      <= (alu_control == MOD_OP);
          busy        <= 1'b1;
          if (is_mul) begin
            state <= MUL_RUN;
          end else if (is_dm && !b_zero) begin
            state <= DIV_RUN;
          end else begin
            // Everything else finishes at this edge.
            state <= DONE;
            done  <= 1'b1;
            if (is_dm) begin
              result      <= dz_res;
              zero        <= (dz_res == '0);
              div_by_zero <= 1'b1;
            end else if (is_single_cycle(alu_control)) begin
              result <= sc_res;
              zero   <= (sc_res == '0);
            end else begin
              result     <= '0;
              zero       <= 1'b1;
              illegal_op <= 1'b1;
            end
          end
        end
        MUL_RUN: if (md_ready) begin
          // md_qp carries the product including this final step.
          result <= md_qp;
          zero   <= (md_qp == '0);
          state  <= DONE;
          done   <= 1'b1;
        end
        DIV_RUN: if (md_ready) state <= DIV_FIX;
        DIV_FIX: begin
          result <= fix_res;
          zero   <= (fix_res == '0);
          state  <= DONE;
          done   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH = 32).
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_control;
  logic [31:0] a, b;
  logic        busy, done, zero, div_by_zero, illegal_op;
  logic [31:0] result;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        dbz;
    logic        ill;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the op definitions.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic dbz, output logic ill,
                       output int lat);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dbz = 0; ill = 0; lat = 1; r = 0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
      4'b1100: r = ~(x | y);
      4'b1000: r = y << 16;
      4'b1001: begin r = 32'(sx * sy); lat = 33; end
      4'b1010: if (y == 0) begin r = 32'hFFFF_FFFF; dbz = 1; end
               else begin r = 32'(sx / sy); lat = 34; end
      4'b1011: if (y == 0) begin r = x; dbz = 1; end
               else begin r = 32'(sx % sy); lat = 34; end
      default: begin r = 0; ill = 1; end
    endcase
  endtask

  // Monitor: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no pending op", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ".result"}, 64'(result), 64'(e.res));
        chk({e.tag, ".zero"},   64'(zero), 64'(e.zero));
        chk({e.tag, ".dbz"},    64'(div_by_zero), 64'(e.dbz));
        chk({e.tag, ".ill"},    64'(illegal_op), 64'(e.ill));
        chk({e.tag, ".latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one op at a negedge; garbles operands after acceptance and
  // optionally pokes start mid-run. Returns once the DUT is back in IDLE.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit poke);
    exp_t e;
    int   lat, bcnt;
    model(op, x, y, e.res, e.dbz, e.ill, lat);
    e.zero = (e.res == 0);
    e.cyc  = cyc + lat;
    e.tag  = tag;
    q.push_back(e);
    start = 1; alu_control = op; a = x; b = y;
    @(posedge clk); #1;
    start = 0; a = $urandom; b = $urandom; alu_control = 4'($urandom);
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (poke && i == 10) begin start = 1; alu_control = 4'b0010; end
      else start = 0;
      if (busy) bcnt++;
      else break;
    end
    start = 0;
    chk({tag, ".busy_cycles"}, 64'(bcnt), 64'(lat));
  endtask

  logic [3:0] legal_ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                                 4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b1011};

  initial begin
    rst_n = 0; start = 0; alu_control = 0; a = 0; b = 0;
    #12;
    chk("reset.busy", 64'(busy), 0);
    chk("reset.done", 64'(done), 0);
    chk("reset.result", 64'(result), 0);
    chk("reset.flags", 64'({zero, div_by_zero, illegal_op}), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    issue("add7_5",  4'b0010, 32'd7, 32'd5, 0);
    issue("sub5_5",  4'b0110, 32'd5, 32'd5, 0);
    issue("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    issue("lui",     4'b1000, 32'h0, 32'h0000_1234, 0);
    issue("nor0",    4'b1100, 32'h0, 32'h0, 0);
    issue("mul_m3_7", 4'b1001, 32'hFFFF_FFFD, 32'd7, 1);
    issue("div_m7_2", 4'b1010, 32'hFFFF_FFF9, 32'd2, 0);
    issue("mod_m7_2", 4'b1011, 32'hFFFF_FFF9, 32'd2, 0);
    issue("div_ovf", 4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue("mod_ovf", 4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue("div_by0", 4'b1010, 32'd9, 32'd0, 0);
    issue("mod_by0", 4'b1011, 32'd9, 32'd0, 0);
    issue("illegal", 4'b0101, 32'd3, 32'd4, 0);
    issue("clear_flags", 4'b0000, 32'hF0F0, 32'hFF00, 0);

    // Reset mid-MUL.
    start = 1; alu_control = 4'b1001; a = 32'd12345; b = 32'd678;
    @(posedge clk); #1; start = 0;
    repeat (10) @(negedge clk);
    rst_n = 0; #1;
    chk("rst_mid.busy", 64'(busy), 0);
    chk("rst_mid.done", 64'(done), 0);
    chk("rst_mid.result", 64'(result), 0);
    q.delete();
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    issue("after_rst_add", 4'b0010, 32'd1, 32'd1, 0);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      int sel;
      sel = $urandom_range(0, 19);
      op  = (sel < 18) ? legal_ops[sel % 10] : 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = $urandom_range(1, 9);
        4: x = y;
        default: ;
      endcase
      issue($sformatf("rnd%0d", n), op, x, y, (n % 7) == 3);
    end

    repeat (3) @(negedge clk);
    chk("drain.pending", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
